// File: rtl/uart_gcd_pipeline.sv
`default_nettype none
// ==== uart_gcd_pipeline : UART-fed subtractive GCD with LED/7-seg/UART result (rev 1.0) ====
module uart_gcd_pipeline #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 9600
) (
  input  logic       reset,
  input  logic       sysclk,
  output logic [7:0] led,
  input  logic [7:0] switch,
  output logic [6:0] digi1,
  output logic [6:0] digi2,
  output logic [6:0] digi3,
  output logic [6:0] digi4,
  input  logic       UART_RX,
  output logic       UART_TX
);
  localparam int BAUD_DIV = CLK_HZ / BAUD;
  localparam int CNT_W    = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] DIV_MAX  = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_MAX = CNT_W'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {WAIT_A, WAIT_B, CALC, SEND} state_t;

  logic             rx_s1, rx_s2, rx_prev;
  rx_state_t        rx_state;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_idx;
  logic [7:0]       rx_sh;
  logic [7:0]       rx_data;
  logic             rx_valid;

  state_t           state;
  logic [7:0]       a, b, x, y, result;
  logic [7:0]       gcd_val;
  logic [CNT_W-1:0] tx_cnt;
  logic [3:0]       tx_idx;
  logic [8:0]       tx_sh;
  logic             tx_line;

  logic             unused_switch;
  assign unused_switch = ^switch[7:1];

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_sh    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_s1    <= UART_RX;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      rx_valid <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_state <= RX_START;
            rx_cnt   <= '0;
          end
        end
        RX_START: begin
          // A start bit that is high again by mid-bit was a glitch.
          if (rx_cnt == HALF_MAX) begin
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == DIV_MAX) begin
            rx_cnt <= '0;
            rx_sh  <= {rx_s2, rx_sh[7:1]};
            rx_idx <= rx_idx + 3'd1;
            if (rx_idx == 3'd7) rx_state <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: begin
          if (rx_cnt == DIV_MAX) begin
            rx_state <= RX_IDLE;
            if (rx_s2) begin
              rx_valid <= 1'b1;
              rx_data  <= rx_sh;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign gcd_val = (x == 8'd0) ? y : x;

  // Working copies x/y are reduced so a/b stay visible on the display.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state   <= WAIT_A;
      a       <= '0;
      b       <= '0;
      x       <= '0;
      y       <= '0;
      result  <= '0;
      tx_cnt  <= '0;
      tx_idx  <= '0;
      tx_sh   <= '1;
      tx_line <= 1'b1;
    end else begin
      case (state)
        WAIT_A: begin
          if (rx_valid) begin
            a     <= rx_data;
            state <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (rx_valid) begin
            b     <= rx_data;
            x     <= a;
            y     <= rx_data;
            state <= CALC;
          end
        end
        CALC: begin
          if (x == 8'd0 || y == 8'd0 || x == y) begin
            result  <= gcd_val;
            tx_sh   <= {1'b1, gcd_val};
            tx_line <= 1'b0;
            tx_cnt  <= '0;
            tx_idx  <= '0;
            state   <= SEND;
          end else if (x > y) begin
            x <= x - y;
          end else begin
            y <= y - x;
          end
        end
        default: begin
          if (tx_cnt == DIV_MAX) begin
            tx_cnt <= '0;
            if (tx_idx == 4'd9) begin
              tx_line <= 1'b1;
              state   <= WAIT_A;
            end else begin
              tx_line <= tx_sh[0];
              tx_sh   <= {1'b1, tx_sh[8:1]};
              tx_idx  <= tx_idx + 4'd1;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;
      4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  logic [7:0] left_byte, right_byte;
  assign left_byte  = switch[0] ? a : rx_data;
  assign right_byte = switch[0] ? b : result;

  assign digi4   = seg7(left_byte[7:4]);
  assign digi3   = seg7(left_byte[3:0]);
  assign digi2   = seg7(right_byte[7:4]);
  assign digi1   = seg7(right_byte[3:0]);
  assign led     = result;
  assign UART_TX = tx_line;
endmodule
`default_nettype wire

// File: tb/tb_uart_gcd_pipeline.sv
`default_nettype none
// ==== tb_uart_gcd_pipeline : directed self-checking bench, reduced baud divider (rev 1.0) ====
module tb_uart_gcd_pipeline;
  localparam int CLK_HZ = 1_600_000;
  localparam int BAUD   = 100_000;
  localparam int CLK_NS = 10;
  localparam int BIT_NS = (CLK_HZ / BAUD) * CLK_NS;

  logic       reset = 1'b1;
  logic       sysclk = 1'b0;
  logic       uart_rx = 1'b1;
  logic       uart_tx;
  logic [7:0] led;
  logic [7:0] switch = 8'h00;
  logic [6:0] digi1, digi2, digi3, digi4;

  int         checks = 0;
  int         errors = 0;
  int         tx_frames = 0;
  logic [7:0] tx_byte = 8'h00;
  logic       tx_stop = 1'b0;

  uart_gcd_pipeline #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .reset  (reset),
    .sysclk (sysclk),
    .led    (led),
    .switch (switch),
    .digi1  (digi1),
    .digi2  (digi2),
    .digi3  (digi3),
    .digi4  (digi4),
    .UART_RX(uart_rx),
    .UART_TX(uart_tx)
  );

  always #(CLK_NS / 2) sysclk = ~sysclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    uart_rx = 1'b1;
    #(BIT_NS);
    uart_rx = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      #(BIT_NS);
    end
    uart_rx = stop;
    #(BIT_NS);
    uart_rx = 1'b1;
    #(BIT_NS);
  endtask

  task automatic wait_frames(input int target, input string tag);
    int n = 0;
    while (tx_frames < target && n < 3000) begin
      @(posedge sysclk);
      n++;
    end
    check(tag, {31'd0, tx_frames >= target}, 32'd1);
  endtask

  task automatic run_pair(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp, input string tag);
    int target = tx_frames + 1;
    send_frame(a, 1'b1);
    send_frame(b, 1'b1);
    wait_frames(target, {tag, "_txdone"});
    #1;
    check({tag, "_led"}, {24'd0, led}, {24'd0, exp});
    check({tag, "_txbyte"}, {24'd0, tx_byte}, {24'd0, exp});
    check({tag, "_txstop"}, {31'd0, tx_stop}, 32'd1);
  endtask

  // Serial monitor: samples each TX bit at its centre after the start edge.
  initial begin
    logic [7:0] d;
    #20;
    forever begin
      @(negedge uart_tx);
      #(BIT_NS / 2);
      for (int i = 0; i < 8; i++) begin
        #(BIT_NS);
        d[i] = uart_tx;
      end
      #(BIT_NS);
      tx_byte = d;
      tx_stop = uart_tx;
      tx_frames++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #3 reset = 1'b0;
    #10;
    check("rst_led", {24'd0, led}, 32'h00);
    check("rst_tx", {31'd0, uart_tx}, 32'd1);
    check("rst_digits", {4'd0, digi4, digi3, digi2, digi1}, {4'd0, {4{7'b1000000}}});
    reset = 1'b1;
    #(BIT_NS * 2);

    run_pair(8'h1B, 8'h78, 8'h03, "gcd27_120");
    check("sw0_digi1", {25'd0, digi1}, {25'd0, 7'b0110000});
    check("sw0_digi2", {25'd0, digi2}, {25'd0, 7'b1000000});
    check("sw0_digi4", {25'd0, digi4}, {25'd0, 7'b1111000});
    check("sw0_digi3", {25'd0, digi3}, {25'd0, 7'b0000000});
    switch = 8'h01;
    #1;
    check("sw1_digi4", {25'd0, digi4}, {25'd0, 7'b1111001});
    check("sw1_digi3", {25'd0, digi3}, {25'd0, 7'b0000011});
    check("sw1_digi2", {25'd0, digi2}, {25'd0, 7'b1111000});
    check("sw1_digi1", {25'd0, digi1}, {25'd0, 7'b0000000});
    switch = 8'hFE;
    #1;
    check("swhi_digi1", {25'd0, digi1}, {25'd0, 7'b0110000});
    switch = 8'h00;

    run_pair(8'h00, 8'h2A, 8'h2A, "gcd0_42");
    run_pair(8'h00, 8'h00, 8'h00, "gcd0_0");
    run_pair(8'h05, 8'h00, 8'h05, "gcd5_0");

    send_frame(8'h55, 1'b0);
    #(BIT_NS * 2);
    check("frame_err_led", {24'd0, led}, 32'h05);
    check("frame_err_last", {18'd0, digi4, digi3}, {18'd0, 7'b1000000, 7'b1000000});
    run_pair(8'h30, 8'h24, 8'h0C, "after_ferr");

    send_frame(8'h09, 1'b1);
    send_frame(8'h06, 1'b1);
    n = 0;
    while (uart_tx !== 1'b0 && n < 1000) begin
      @(posedge sysclk);
      n++;
    end
    check("send_seen", {31'd0, uart_tx === 1'b0}, 32'd1);
    #(BIT_NS * 3 + 3);
    reset = 1'b0;
    #1;
    check("midsend_tx", {31'd0, uart_tx}, 32'd1);
    check("midsend_led", {24'd0, led}, 32'h00);
    check("midsend_digits", {4'd0, digi4, digi3, digi2, digi1}, {4'd0, {4{7'b1000000}}});
    #10;
    reset = 1'b1;
    #(BIT_NS * 12);

    run_pair(8'h0C, 8'h12, 8'h06, "gcd12_18");
    check("final_digi1", {25'd0, digi1}, {25'd0, 7'b0000010});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
